time_frame_builder: RTL and testbench



---
 rtl/time_frame_builder_if.sv | 19 +
 rtl/time_frame_builder.sv | 161 ++++++++++++++++
 tb/tb_time_frame_builder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_frame_builder_if.sv
// Frame handoff bundle between the time frame builder and the serialiser.
// The master drives dReady/dataOut, and the slave answers with ldcReady.
interface time_frame_builder_if;
    logic        dReady;
    logic        ldcReady;
    logic [23:0] dataOut;

    modport master (
        output dReady,
        output dataOut,
        input  ldcReady
    );

    modport slave (
        input  dReady,
        input  dataOut,
        output ldcReady
    );
endinterface

// File: rtl/time_frame_builder.sv
// Converts both players' seconds to mm:ss BCD frames without a divider.
// Optional low-time flag: define TIME_FRAME_LOW_TIME_FLAG_EN.
module time_frame_builder #(
    parameter int MAX_S      = 5999,
    parameter int LOW_TIME_S = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_update,
    input  logic [12:0]          i_timeA,
    input  logic [12:0]          i_timeB,
    input  logic                 i_activeB,
    output logic                 o_busy,
    time_frame_builder_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, DIV60, BCDM, BCDS, SEND, WAIT
    } state_t;

    localparam logic [12:0] MAX13 = 13'(MAX_S);

    state_t      r_state;
    logic [12:0] r_capA;
    logic [12:0] r_capB;
    logic        r_capAct;
    logic        r_selB;
    logic        r_pending;
    logic [12:0] r_rem;
    logic [6:0]  r_min;
    logic [3:0]  r_mt;
    logic [3:0]  r_st;
    logic        r_zero;
    logic        r_low;
    logic        r_dReady;
    logic [23:0] r_dataOut;
    logic        r_busy;

    logic [12:0] w_sel;
    logic [12:0] w_sat;
    logic        w_active;
    logic        w_low;
    logic        w_final;
    logic        w_merge;

    assign w_sel    = r_selB ? r_capB : r_capA;
    assign w_sat    = (w_sel > MAX13) ? MAX13 : w_sel;
    assign w_active = r_selB ? r_capAct : ~r_capAct;
    assign w_final  = (r_state == WAIT) && bus.ldcReady && r_selB;
    assign w_merge  = r_pending | i_update;

`ifdef TIME_FRAME_LOW_TIME_FLAG_EN
    assign w_low = (w_sat != 13'd0) && (w_sat < 13'(LOW_TIME_S));
`else
    // Constant-folds to zero; the threshold only matters when the flag is built in.
    assign w_low = 1'b0 & (LOW_TIME_S != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_capA    <= '0;
            r_capB    <= '0;
            r_capAct  <= 1'b0;
            r_selB    <= 1'b0;
            r_pending <= 1'b0;
            r_rem     <= '0;
            r_min     <= '0;
            r_mt      <= '0;
            r_st      <= '0;
            r_zero    <= 1'b0;
            r_low     <= 1'b0;
            r_dReady  <= 1'b0;
            r_dataOut <= '0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_update) begin
                        r_capA    <= i_timeA;
                        r_capB    <= i_timeB;
                        r_capAct  <= i_activeB;
                        r_selB    <= 1'b0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    r_rem   <= w_sat;
                    r_min   <= '0;
                    r_mt    <= '0;
                    r_st    <= '0;
                    r_zero  <= (w_sat == 13'd0);
                    r_low   <= w_low;
                    r_state <= DIV60;
                end
                DIV60: begin
                    if (r_rem >= 13'd60) begin
                        r_rem <= r_rem - 13'd60;
                        r_min <= r_min + 7'd1;
                    end else begin
                        r_state <= BCDM;
                    end
                end
                // Tens digits peel off; the units remain in the low nibble.
                BCDM: begin
                    if (r_min >= 7'd10) begin
                        r_min <= r_min - 7'd10;
                        r_mt  <= r_mt + 4'd1;
                    end else begin
                        r_state <= BCDS;
                    end
                end
                BCDS: begin
                    if (r_rem >= 13'd10) begin
                        r_rem <= r_rem - 13'd10;
                        r_st  <= r_st + 4'd1;
                    end else begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    r_dataOut <= {r_selB ? 4'hB : 4'hA,
                                  1'b0, r_low, w_active, r_zero,
                                  r_mt, r_min[3:0],
                                  r_st, r_rem[3:0]};
                    r_dReady  <= 1'b1;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (bus.ldcReady) begin
                        r_dReady <= 1'b0;
                        if (!r_selB) begin
                            r_selB  <= 1'b1;
                            r_state <= LOAD;
                        end else if (w_merge) begin
                            r_capA    <= i_timeA;
                            r_capB    <= i_timeB;
                            r_capAct  <= i_activeB;
                            r_selB    <= 1'b0;
                            r_pending <= 1'b0;
                            r_state   <= LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Requests during a pair merge into one refresh after it.
            if (i_update && (r_state != IDLE) && !w_final) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.dReady  = r_dReady;
    assign bus.dataOut = r_dataOut;
    assign o_busy      = r_busy;
endmodule

// File: tb/tb_time_frame_builder.sv
// Randomized and directed bench for time_frame_builder against a
// frame-level model of the mm:ss conversion and the pair/merge rules.
module tb_time_frame_builder;
  logic        clk = 1'b0;
  logic        rst;
  logic        update;
  logic [12:0] timeA;
  logic [12:0] timeB;
  logic        activeB;
  logic        busy;

  time_frame_builder_if bus();

  time_frame_builder dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_update  (update),
    .i_timeA   (timeA),
    .i_timeB   (timeB),
    .i_activeB (activeB),
    .o_busy    (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];
  logic [23:0] log_q[$];
  bit          mbusy    = 0;
  bit          mpend    = 0;
  bit          chk_zero = 0;
  bit          prev_dr  = 0;
  bit          prev_acc = 0;
  int          nacc     = 0;
  int          starve   = 0;
  logic [23:0] prev_do  = '0;

  task automatic chk(input string nm, input logic [23:0] act,
                     input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input int t, input bit isB,
                                     input bit actB);
    int s;
    int m;
    int sec;
    bit lo;
    s   = (t > 5999) ? 5999 : t;
    m   = s / 60;
    sec = s % 60;
`ifdef TIME_FRAME_LOW_TIME_FLAG_EN
    lo = (s > 0) && (s < 10);
`else
    lo = 1'b0;
`endif
    return {isB ? 4'hB : 4'hA,
            1'b0, lo, (isB == actB), (s == 0),
            4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  function automatic logic [23:0] lg(input int i);
    return (i < log_q.size()) ? log_q[i] : 24'hxxxxxx;
  endfunction

  task automatic push_pair();
    exp_q.push_back(mk(int'(timeA), 1'b0, activeB));
    exp_q.push_back(mk(int'(timeB), 1'b1, activeB));
  endtask

  // Outputs and the inputs for the coming edge are both stable here.
  always @(negedge clk) begin
    bit acc;
    bit fin;
    if (rst) begin
      exp_q.delete();
      mbusy    = 0;
      mpend    = 0;
      nacc     = 0;
      starve   = 0;
      chk_zero = 1;
      prev_dr  = 0;
      prev_acc = 0;
    end else begin
      if (chk_zero) begin
        chk("rst_dready", 24'(bus.dReady), 24'd0);
        chk("rst_data", bus.dataOut, 24'd0);
        chk("rst_busy", 24'(busy), 24'd0);
        chk_zero = 0;
      end
      chk("busy", 24'(busy), 24'(mbusy));
      if (bus.dReady) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_frame: got %h required none",
                   bus.dataOut);
        end else begin
          chk("frame", bus.dataOut, exp_q[0]);
        end
      end
      if (prev_dr && !prev_acc) begin
        chk("hold_dready", 24'(bus.dReady), 24'd1);
        chk("hold_data", bus.dataOut, prev_do);
      end
      if (prev_acc) chk("pulse_end", 24'(bus.dReady), 24'd0);
      if (mbusy && !bus.dReady) begin
        starve++;
        chk("latency", 24'(starve <= 125), 24'd1);
        if (starve > 125) starve = 0;
      end else begin
        starve = 0;
      end
      acc = bus.dReady && bus.ldcReady;
      fin = 0;
      if (acc && exp_q.size() > 0) begin
        log_q.push_back(bus.dataOut);
        void'(exp_q.pop_front());
        nacc++;
        if (nacc == 2) begin
          nacc = 0;
          fin  = 1;
          if (mpend || update) begin
            push_pair();
            mpend = 0;
          end else begin
            mbusy = 0;
          end
        end
      end
      if (update && !fin) begin
        if (!mbusy) begin
          push_pair();
          mbusy = 1;
        end else begin
          mpend = 1;
        end
      end
      prev_dr  = bus.dReady;
      prev_acc = acc;
      prev_do  = bus.dataOut;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    int k = 0;
    do begin
      tick();
      k++;
    end while (busy && k < n);
    chk("idle_timeout", 24'(busy), 24'd0);
  endtask

  task automatic wait_dr(input int n);
    int k = 0;
    while (!bus.dReady && k < n) begin
      tick();
      k++;
    end
    chk("dready_timeout", 24'(bus.dReady), 24'd1);
  endtask

  function automatic logic [12:0] pick();
    unique case ($urandom_range(0, 7))
      0: return 13'd0;
      1: return 13'($urandom_range(1, 12));
      2: return 13'(59 + $urandom_range(0, 2));
      3: return 13'(5998 + $urandom_range(0, 3));
      4: return 13'd8191;
      default: return 13'($urandom_range(0, 8191));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst           = 1'b1;
    update        = 1'b0;
    activeB       = 1'b0;
    timeA         = '0;
    timeB         = '0;
    bus.ldcReady  = 1'b0;

    chk("model_754", mk(754, 1'b0, 1'b0), 24'hA21234);
    chk("model_8191", mk(8191, 1'b1, 1'b1), 24'hB29959);
    chk("model_61", mk(61, 1'b0, 1'b0), 24'hA20101);

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Basic pair with immediate acceptance
    bus.ldcReady = 1'b1;
    timeA = 13'd754; timeB = 13'd300; activeB = 1'b0;
    log_q.delete();
    pulse_update();
    wait_idle(600);
    chk("t1_count", 24'(log_q.size()), 24'd2);
    chk("t1_a", lg(0), 24'hA21234);
    chk("t1_b", lg(1), 24'hB00500);

    // Zero and saturation
    timeA = 13'd0; timeB = 13'd8191; activeB = 1'b1;
    log_q.delete();
    pulse_update();
    wait_idle(600);
    chk("t2_a", lg(0), 24'hA10000);
    chk("t2_b", lg(1), 24'hB29959);

    // Stalled acceptance
    bus.ldcReady = 1'b0;
    timeA = 13'd100; timeB = 13'd200; activeB = 1'b1;
    log_q.delete();
    pulse_update();
    wait_dr(200);
    repeat (50) tick();
    chk("t3_hold", 24'(bus.dReady), 24'd1);
    bus.ldcReady = 1'b1;
    tick();
    bus.ldcReady = 1'b0;
    chk("t3_fall", 24'(bus.dReady), 24'd0);
    chk("t3_busy", 24'(busy), 24'd1);
    wait_dr(200);
    bus.ldcReady = 1'b1;
    wait_idle(200);
    chk("t3_a", lg(0), 24'hA00140);
    chk("t3_b", lg(1), 24'hB20320);

    // Merged requests during the A conversion
    timeA = 13'd754; timeB = 13'd300; activeB = 1'b0;
    log_q.delete();
    pulse_update();
    repeat (2) tick();
    pulse_update();
    timeA = 13'd61;
    repeat (3) tick();
    pulse_update();
    wait_idle(1000);
    chk("t4_count", 24'(log_q.size()), 24'd4);
    chk("t4_a2", lg(2), 24'hA20101);
    chk("t4_b2", lg(3), 24'hB00500);

    // Reset in the middle of DIV60
    timeA = 13'd5999;
    pulse_update();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_dready", 24'(bus.dReady), 24'd0);
    chk("t5_data", bus.dataOut, 24'd0);
    chk("t5_busy", 24'(busy), 24'd0);
    log_q.delete();
    repeat (200) tick();
    chk("t5_noframe", 24'(log_q.size()), 24'd0);

    // Low-time threshold
    timeA = 13'd9; timeB = 13'd5999; activeB = 1'b0;
    log_q.delete();
    pulse_update();
    wait_idle(600);
`ifdef TIME_FRAME_LOW_TIME_FLAG_EN
    chk("t6_a", lg(0), 24'hA60009);
`else
    chk("t6_a", lg(0), 24'hA20009);
`endif
    chk("t6_b", lg(1), 24'hB09959);

    // Random traffic
    for (int c = 0; c < 6000; c++) begin
      update       = ($urandom_range(0, 99) < 2);
      bus.ldcReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        timeA   = pick();
        timeB   = pick();
        activeB = 1'($urandom_range(0, 1));
      end
      tick();
    end
    update       = 1'b0;
    bus.ldcReady = 1'b1;
    wait_idle(1200);
    chk("drained", 24'(exp_q.size()), 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
